// File: rtl/pc_sequencer.sv
// Control sequencer for a Hack-style CPU: fetches instruction words from ROM,
// decodes them into single-cycle register/PC strobes, and detects halt/fault conditions.
module pc_sequencer #(
  parameter int ROM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [15:0] instr,
  input  logic        rom_ack,
  input  logic        zr,
  input  logic        ng,
  input  logic [15:0] pc_value,
  input  logic [15:0] a_value,
  output logic        rom_req,
  output logic        pc_reset,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        a_load,
  output logic        d_load,
  output logic        m_write,
  output logic [15:0] ir,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  localparam int WAIT_W = (ROM_TIMEOUT < 2) ? 1 : $clog2(ROM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    HOLD,
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t state, state_next;

  logic              step_q;
  logic              step_armed;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_q;
  logic              step_edge;
  logic              jump_taken;
  logic              self_loop;
  logic              fetch_timeout;

  assign step_edge     = step & ~step_q;
  assign jump_taken    = ir[15] & ((ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr));
  // A taken jump onto its own address can never make progress, so it halts the machine.
  assign self_loop     = jump_taken & (a_value == pc_value);
  assign fetch_timeout = ~rom_ack & (wait_cnt == WAIT_W'(ROM_TIMEOUT - 1));

  assign halted = (state == HALT);
  assign fault  = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HOLD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rom_req    = 1'b0;
    pc_reset   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    a_load     = 1'b0;
    d_load     = 1'b0;
    m_write    = 1'b0;
    case (state)
      HOLD: begin
        pc_reset   = 1'b1;
        state_next = IDLE;
      end
      IDLE: begin
        if (run || step_armed) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        rom_req = 1'b1;
        if (rom_ack) begin
          state_next = EXEC;
        end else if (fetch_timeout) begin
          state_next = HALT;
        end
      end
      EXEC: begin
        if (!ir[15]) begin
          a_load = 1'b1;
          pc_inc = 1'b1;
        end else begin
          a_load  = ir[5];
          d_load  = ir[4];
          m_write = ir[3];
          pc_load = jump_taken;
          pc_inc  = ~jump_taken;
        end
        if (self_loop) begin
          state_next = HALT;
        end else if (run) begin
          state_next = FETCH;
        end else begin
          state_next = IDLE;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = HOLD;
      end
    endcase
  end

  // Datapath registers: step edge detector, ROM wait counter, IR and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q      <= 1'b0;
      step_armed  <= 1'b0;
      wait_cnt    <= '0;
      ir          <= 16'h0000;
      instr_count <= 16'h0000;
      fault_q     <= 1'b0;
    end else begin
      step_q <= step;
      if (state == IDLE && state_next == FETCH) begin
        step_armed <= 1'b0;
      end else if (state == IDLE && step_edge) begin
        step_armed <= 1'b1;
      end
      if (state == FETCH) begin
        if (rom_ack) begin
          ir       <= instr;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
          if (fetch_timeout) begin
            fault_q <= 1'b1;
          end
        end
      end
      if (state == EXEC) begin
        instr_count <= instr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer; each task drives one scenario and checks
// outputs against hand-computed values on the falling clock edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic [15:0] instr;
  logic        rom_ack;
  logic        zr;
  logic        ng;
  logic [15:0] pc_value;
  logic [15:0] a_value;
  logic        rom_req;
  logic        pc_reset;
  logic        pc_inc;
  logic        pc_load;
  logic        a_load;
  logic        d_load;
  logic        m_write;
  logic [15:0] ir;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int n_checks;
  int n_fails;

  pc_sequencer #(.ROM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .instr      (instr),
    .rom_ack    (rom_ack),
    .zr         (zr),
    .ng         (ng),
    .pc_value   (pc_value),
    .a_value    (a_value),
    .rom_req    (rom_req),
    .pc_reset   (pc_reset),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .a_load     (a_load),
    .d_load     (d_load),
    .m_write    (m_write),
    .ir         (ir),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for two cycles; caller sets inputs and then releases.
  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0; instr = 16'h0000; rom_ack = 1'b0;
    zr = 1'b0; ng = 1'b0; pc_value = 16'd0; a_value = 16'd0;
    tick();
    tick();
    n_checks++; if (pc_reset !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_pc_reset got %b exp 1", pc_reset); end
    n_checks++; if (rom_req !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_rom_req got %b exp 0", rom_req); end
    n_checks++; if (ir !== 16'h0000) begin n_fails++; $display("[TB] FAIL rst_ir got %h exp 0000", ir); end
    n_checks++; if (instr_count !== 16'h0000) begin n_fails++; $display("[TB] FAIL rst_count got %h exp 0000", instr_count); end
    n_checks++; if ({halted, fault} !== 2'b00) begin n_fails++; $display("[TB] FAIL rst_flags got %b exp 00", {halted, fault}); end
    n_checks++; if ({pc_inc, pc_load, a_load, d_load, m_write} !== 5'b0) begin
      n_fails++; $display("[TB] FAIL rst_strobes got %b exp 00000", {pc_inc, pc_load, a_load, d_load, m_write}); end
  endtask

  task automatic test_free_run();
    hold_reset();
    run = 1'b1; rom_ack = 1'b1; instr = 16'h0005;
    reset = 1'b1;
    n_checks++; if (pc_reset !== 1'b1) begin n_fails++; $display("[TB] FAIL fr_hold_pc_reset got %b exp 1", pc_reset); end
    tick();
    n_checks++; if ({pc_reset, rom_req} !== 2'b00) begin n_fails++; $display("[TB] FAIL fr_idle got %b exp 00", {pc_reset, rom_req}); end
    tick();
    n_checks++; if (rom_req !== 1'b1) begin n_fails++; $display("[TB] FAIL fr_first_fetch got %b exp 1", rom_req); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if ({a_load, pc_inc, pc_load, rom_req, pc_reset} !== 5'b11000) begin
        n_fails++; $display("[TB] FAIL fr_exec%0d got %b exp 11000", k, {a_load, pc_inc, pc_load, rom_req, pc_reset}); end
      n_checks++; if (ir !== 16'h0005) begin n_fails++; $display("[TB] FAIL fr_ir%0d got %h exp 0005", k, ir); end
      tick();
      n_checks++; if (rom_req !== 1'b1 || a_load !== 1'b0) begin
        n_fails++; $display("[TB] FAIL fr_fetch%0d got req=%b a_load=%b exp 1 0", k, rom_req, a_load); end
      n_checks++; if (instr_count !== 16'(k)) begin n_fails++; $display("[TB] FAIL fr_count%0d got %0d exp %0d", k, instr_count, k); end
    end
  endtask

  task automatic test_jump();
    hold_reset();
    run = 1'b1; rom_ack = 1'b1; instr = 16'hE302; zr = 1'b1; ng = 1'b0;
    a_value = 16'd100; pc_value = 16'd5;
    reset = 1'b1;
    tick(); tick(); tick();
    n_checks++; if ({pc_load, pc_inc, a_load, d_load, m_write} !== 5'b10000) begin
      n_fails++; $display("[TB] FAIL jeq_taken got %b exp 10000", {pc_load, pc_inc, a_load, d_load, m_write}); end
    tick();
    zr = 1'b0;
    tick();
    n_checks++; if ({pc_load, pc_inc} !== 2'b01) begin n_fails++; $display("[TB] FAIL jeq_not_taken got %b exp 01", {pc_load, pc_inc}); end
    instr = 16'hEC38;
    tick(); tick();
    n_checks++; if ({a_load, d_load, m_write, pc_inc, pc_load} !== 5'b11110) begin
      n_fails++; $display("[TB] FAIL cdest got %b exp 11110", {a_load, d_load, m_write, pc_inc, pc_load}); end
    instr = 16'hE304; ng = 1'b1;
    tick(); tick();
    n_checks++; if ({pc_load, pc_inc} !== 2'b10) begin n_fails++; $display("[TB] FAIL jlt_taken got %b exp 10", {pc_load, pc_inc}); end
    instr = 16'hE301;
    tick(); tick();
    n_checks++; if ({pc_load, pc_inc} !== 2'b01) begin n_fails++; $display("[TB] FAIL jgt_neg got %b exp 01", {pc_load, pc_inc}); end
    ng = 1'b0;
    tick(); tick();
    n_checks++; if ({pc_load, pc_inc} !== 2'b10) begin n_fails++; $display("[TB] FAIL jgt_pos got %b exp 10", {pc_load, pc_inc}); end
    n_checks++; if (halted !== 1'b0) begin n_fails++; $display("[TB] FAIL jmp_no_halt got %b exp 0", halted); end
  endtask

  task automatic test_self_loop();
    logic bad;
    hold_reset();
    run = 1'b1; rom_ack = 1'b1; instr = 16'hE307; zr = 1'b0; ng = 1'b0;
    a_value = 16'd12; pc_value = 16'd12;
    reset = 1'b1;
    tick(); tick(); tick();
    n_checks++; if ({pc_load, pc_inc, halted} !== 3'b100) begin
      n_fails++; $display("[TB] FAIL loop_exec got %b exp 100", {pc_load, pc_inc, halted}); end
    tick();
    n_checks++; if ({halted, fault} !== 2'b10) begin n_fails++; $display("[TB] FAIL loop_halt got %b exp 10", {halted, fault}); end
    n_checks++; if (instr_count !== 16'd1) begin n_fails++; $display("[TB] FAIL loop_count got %0d exp 1", instr_count); end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rom_req || pc_load || pc_inc || a_load || !halted) bad = 1'b1;
      tick();
    end
    n_checks++; if (bad !== 1'b0) begin n_fails++; $display("[TB] FAIL loop_stays_halted got %b exp 0", bad); end
  endtask

  task automatic test_timeout();
    int  cycles;
    logic bad;
    hold_reset();
    run = 1'b1; rom_ack = 1'b0; instr = 16'h0005;
    reset = 1'b1;
    tick(); tick();
    cycles = 0;
    bad = 1'b0;
    while (rom_req && cycles < 40) begin
      if (pc_inc || pc_load) bad = 1'b1;
      cycles++;
      tick();
    end
    n_checks++; if (cycles !== 15) begin n_fails++; $display("[TB] FAIL to_fetch_cycles got %0d exp 15", cycles); end
    n_checks++; if ({halted, fault} !== 2'b11) begin n_fails++; $display("[TB] FAIL to_flags got %b exp 11", {halted, fault}); end
    for (int i = 0; i < 3; i++) begin
      if (pc_inc || pc_load || rom_req) bad = 1'b1;
      tick();
    end
    n_checks++; if (bad !== 1'b0) begin n_fails++; $display("[TB] FAIL to_pc_strobe got %b exp 0", bad); end
    n_checks++; if (instr_count !== 16'd0) begin n_fails++; $display("[TB] FAIL to_count got %0d exp 0", instr_count); end
  endtask

  task automatic test_step();
    int execs;
    hold_reset();
    run = 1'b0; rom_ack = 1'b1; instr = 16'h0005; step = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (rom_req !== 1'b0) begin n_fails++; $display("[TB] FAIL step_idle got %b exp 0", rom_req); end
    execs = 0;
    for (int p = 1; p <= 2; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (a_load) execs++;
        tick();
      end
      n_checks++; if (instr_count !== 16'(p)) begin n_fails++; $display("[TB] FAIL step%0d_count got %0d exp %0d", p, instr_count, p); end
      n_checks++; if ({rom_req, a_load} !== 2'b00) begin n_fails++; $display("[TB] FAIL step%0d_idle got %b exp 00", p, {rom_req, a_load}); end
    end
    n_checks++; if (execs !== 2) begin n_fails++; $display("[TB] FAIL step_execs got %0d exp 2", execs); end
  endtask

  task automatic test_reset_in_exec();
    hold_reset();
    run = 1'b1; rom_ack = 1'b1; instr = 16'h0005; step = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    n_checks++; if ({a_load, pc_inc} !== 2'b11) begin n_fails++; $display("[TB] FAIL rexec_pre got %b exp 11", {a_load, pc_inc}); end
    reset = 1'b0;
    #1;
    n_checks++; if ({a_load, pc_inc, pc_load, d_load, m_write, rom_req} !== 6'b0) begin
      n_fails++; $display("[TB] FAIL rexec_strobes got %b exp 000000", {a_load, pc_inc, pc_load, d_load, m_write, rom_req}); end
    n_checks++; if (pc_reset !== 1'b1) begin n_fails++; $display("[TB] FAIL rexec_pc_reset got %b exp 1", pc_reset); end
    n_checks++; if (instr_count !== 16'd0 || ir !== 16'h0000) begin
      n_fails++; $display("[TB] FAIL rexec_regs got count=%0d ir=%h exp 0 0000", instr_count, ir); end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_free_run();
    test_jump();
    test_self_loop();
    test_timeout();
    test_step();
    test_reset_in_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: ROM_TIMEOUT, default 15, max cycles waited for rom_ack before a fetch fault.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; 1 = free-run, 0 = single-step mode.
REQ-005 step  input  1  single-step request; rising edge arms one instruction.
REQ-006 instr  input  16  instruction word from instruction ROM.
REQ-007 rom_ack  input  1  instr valid this cycle.
REQ-008 zr, ng  input  1 each  ALU zero / negative flags, valid in EXEC.
REQ-009 pc_value, a_value  input  16 each  current program counter and A register contents.
REQ-010 rom_req  output  1  fetch request to ROM.
REQ-011 pc_reset, pc_inc, pc_load  output  1 each  program counter controls; pc_load selects a_value as the jump target.
REQ-012 a_load, d_load, m_write  output  1 each  register and memory write strobes.
REQ-013 ir  output  16  latched instruction.
REQ-014 halted, fault  output  1 each  status flags.
REQ-015 instr_count  output  16  retired-instruction counter.

Function
REQ-016 States: HOLD, IDLE, FETCH, EXEC, HALT; encoding free.
REQ-017 HOLD: pc_reset=1 for exactly one cycle, then IDLE.
REQ-018 IDLE: advance to FETCH when run=1 or step_armed=1; otherwise remain.
REQ-019 step_armed set on step 0->1 (step registered once, edge detected); cleared on entering FETCH; step edges outside IDLE are ignored.
REQ-020 FETCH: rom_req=1; on rom_ack capture instr into ir, go EXEC, clear wait counter.
REQ-021 Wait counter increments each FETCH cycle without rom_ack; on reaching ROM_TIMEOUT without ack -> HALT with fault=1, no PC strobe.
REQ-022 EXEC lasts exactly one cycle; exactly one of pc_inc/pc_load is 1; strobes are single-cycle pulses, never asserted outside EXEC (pc_reset excepted).
REQ-023 A-instruction (ir[15]=0): a_load=1, pc_inc=1, d_load=m_write=0.
REQ-024 C-instruction: a_load=ir[5], d_load=ir[4], m_write=ir[3].
REQ-025 Jump taken = (ir[2]&ng) | (ir[1]&zr) | (ir[0]&~ng&~zr); taken -> pc_load=1, else pc_inc=1.
REQ-026 Jump taken with a_value==pc_value (self-loop) -> pc_load still asserted, then HALT with halted=1, fault=0.
REQ-027 EXEC exit without halt: run=1 -> FETCH; run=0 -> IDLE.
REQ-028 instr_count increments by 1 on every EXEC cycle, including the halting one; wraps 16'hFFFF -> 0.
REQ-029 HALT: all strobes 0; left only via reset; halted=1 also when fault=1.
REQ-030 run dropped during FETCH: current fetch completes and executes, then IDLE.
REQ-031 ir holds its value outside the capture cycle.

Reset
REQ-032 While reset=0: state HOLD, ir=0, instr_count=0, wait counter=0, step_armed=0, halted=fault=0, all strobes 0 except pc_reset=1.
REQ-033 Reset asserted mid-FETCH or mid-EXEC aborts immediately; no partial strobe after the asserting edge.
REQ-034 After reset release, first rom_req no earlier than the second rising edge.

Verification
REQ-035 Reset release, run=1, rom_ack tied 1, instr=16'h0005 -> pc_reset one cycle, then alternating FETCH/EXEC, a_load and pc_inc each EXEC, instr_count=3 after three EXEC cycles.
REQ-036 C-instr 16'hE302 (D;JEQ-style, ir[1]=1), zr=1, ng=0 -> pc_load=1, pc_inc=0; same with zr=0 -> pc_inc=1.
REQ-037 ir[2:0]=3'b111, a_value=pc_value=16'd12 -> pc_load pulse, then halted=1, fault=0, no further rom_req.
REQ-038 rom_ack held 0, ROM_TIMEOUT=15 -> HALT after 15 FETCH cycles, fault=1, pc_inc/pc_load never asserted.
REQ-039 run=0, two step pulses -> exactly two EXEC cycles, instr_count=2, state IDLE between steps.
REQ-040 reset dropped low during EXEC with ir[15]=0 -> strobes 0 immediately, instr_count=0, pc_reset=1.
